// File: rtl/sseg_pkg.sv
// Shared types, constants and helpers for the seven-segment scan display.
package sseg_pkg;

  typedef logic [3:0] hex_digit_t;
  typedef logic [7:0] sseg_t;

  // Segment bus with every segment and the dp dark (active-low).
  localparam sseg_t SSEG_BLANK = 8'hFF;

  // Widest digit-select vector the helper can build.
  localparam int unsigned MAX_DIGITS = 8;

  // Active-low one-hot select for digit idx; all ones if idx is outside 0..n-1.
  function automatic logic [MAX_DIGITS-1:0] sel_onehot_n(input int unsigned idx,
                                                          input int unsigned n);
    logic [MAX_DIGITS-1:0] one_hot;
    one_hot = MAX_DIGITS'(1) << idx;
    if (idx < n) begin
      return ~one_hot;
    end
    return '1;
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Hex nibble to active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is always dark here.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  hex_digit_t i_hex,
  output sseg_t      o_sseg_n
);

  // Pure lookup; the caller owns the dp bit.
  always_comb begin
    o_sseg_n = SSEG_BLANK;
    case (i_hex)
      4'h0:    o_sseg_n = 8'hC0;
      4'h1:    o_sseg_n = 8'hF9;
      4'h2:    o_sseg_n = 8'hA4;
      4'h3:    o_sseg_n = 8'hB0;
      4'h4:    o_sseg_n = 8'h99;
      4'h5:    o_sseg_n = 8'h92;
      4'h6:    o_sseg_n = 8'h82;
      4'h7:    o_sseg_n = 8'hF8;
      4'h8:    o_sseg_n = 8'h80;
      4'h9:    o_sseg_n = 8'h90;
      4'hA:    o_sseg_n = 8'h88;
      4'hB:    o_sseg_n = 8'h83;
      4'hC:    o_sseg_n = 8'hC6;
      4'hD:    o_sseg_n = 8'hA1;
      4'hE:    o_sseg_n = 8'h86;
      default: o_sseg_n = 8'h8E;
    endcase
  end

endmodule

// File: rtl/sseg_scan_timer.sv
// Slot counter, scan index and PWM counter; o_drive is high when a digit may be lit.
module sseg_scan_timer #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned PWM_W        = 4,
  localparam int unsigned IDX_W       = $clog2(N_DIGITS),
  localparam int unsigned SLOT_W      = $clog2(SLOT_CYCLES)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [PWM_W-1:0] i_bright,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_drive
);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PWM_W-1:0]  pwm_q, pwm_d;
  logic              guard;
  logic              pwm_on;

  // Next-state for the counters and the drive-enable decode.
  always_comb begin
    slot_d = slot_q + 1'b1;
    idx_d  = idx_q;
    pwm_d  = pwm_q + 1'b1;
    if (slot_q == SLOT_W'(SLOT_CYCLES - 1)) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    guard   = slot_q < SLOT_W'(GUARD_CYCLES);
    // All-ones brightness must be fully on, not one step short.
    pwm_on  = (pwm_q < i_bright) || (&i_bright);
    o_drive = !guard && pwm_on;
    o_idx   = idx_q;
  end

  // Counter state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slot_q <= '0;
      idx_q  <= '0;
      pwm_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
      pwm_q  <= pwm_d;
    end
  end

endmodule

// File: rtl/sseg_scan_display.sv
// N-digit multiplexed hex display: digit register file, scan, dp, leading-zero blanking, PWM.
// i_reset asserts asynchronously; its release is expected to be synchronous to i_clk.
module sseg_scan_display
  import sseg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned PWM_W        = 4,
  localparam int unsigned IDX_W       = $clog2(N_DIGITS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_addr,
  input  logic [3:0]          i_wr_data,
  input  logic                i_wr_dp,
  input  logic                i_shift_en,
  input  logic                i_blank_lz,
  input  logic [PWM_W-1:0]    i_bright,
  output logic [7:0]          o_sseg_n,
  output logic [N_DIGITS-1:0] o_ldsel
);

  hex_digit_t            digit_q [N_DIGITS];
  hex_digit_t            digit_d [N_DIGITS];
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [N_DIGITS-1:0]   lz_blank;
  logic                  nz_seen;
  logic [IDX_W-1:0]      idx;
  logic                  drive;
  hex_digit_t            cur_digit;
  sseg_t                 cur_seg;
  logic [MAX_DIGITS-1:0] sel_full;
  logic                  unused_sel;
  sseg_t                 sseg_q, sseg_d;
  logic [N_DIGITS-1:0]   ldsel_q, ldsel_d;

  sseg_scan_timer #(
    .N_DIGITS    (N_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES),
    .GUARD_CYCLES(GUARD_CYCLES),
    .PWM_W       (PWM_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_bright(i_bright),
    .o_idx   (idx),
    .o_drive (drive)
  );

  hex_to_sseg u_dec (
    .i_hex   (cur_digit),
    .o_sseg_n(cur_seg)
  );

  // Register-file next state: clear beats write beats shift.
  always_comb begin
    digit_d = digit_q;
    dp_d    = dp_q;
    if (i_clear) begin
      digit_d = '{default: '0};
      dp_d    = '0;
    end else if (i_wr_en) begin
      if (32'(i_wr_addr) < N_DIGITS) begin
        digit_d[i_wr_addr] = i_wr_data;
        dp_d[i_wr_addr]    = i_wr_dp;
      end
    end else if (i_shift_en) begin
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
        digit_d[k] = digit_q[k-1];
      end
      digit_d[0] = i_wr_data;
      dp_d       = {dp_q[N_DIGITS-2:0], i_wr_dp};
    end
  end

  // A digit is a leading zero if it and everything to its left is 0 with dp dark.
  always_comb begin
    lz_blank = '0;
    nz_seen  = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nz_seen     = nz_seen | (digit_q[k] != 4'h0) | dp_q[k];
      lz_blank[k] = ~nz_seen;
    end
    lz_blank[0] = 1'b0;
  end

  // Output next state from the current scan position; blank digits keep their select low.
  always_comb begin
    cur_digit  = digit_q[idx];
    sel_full   = sel_onehot_n(32'(idx), N_DIGITS);
    unused_sel = ^sel_full;
    sseg_d     = SSEG_BLANK;
    ldsel_d    = '1;
    if (drive) begin
      ldsel_d = sel_full[N_DIGITS-1:0];
      if (!(i_blank_lz && lz_blank[idx])) begin
        sseg_d = {~dp_q[idx], cur_seg[6:0]};
      end
    end
  end

  // Digit registers and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      digit_q <= '{default: '0};
      dp_q    <= '0;
      sseg_q  <= SSEG_BLANK;
      ldsel_q <= '1;
    end else begin
      digit_q <= digit_d;
      dp_q    <= dp_d;
      sseg_q  <= sseg_d;
      ldsel_q <= ldsel_d;
    end
  end

  assign o_sseg_n = sseg_q;
  assign o_ldsel  = ldsel_q;

endmodule

// File: tb/tb_sseg_scan_display.sv
// Directed bench for sseg_scan_display with a short slot and 2-bit PWM.
module tb_sseg_scan_display;

  localparam int unsigned N  = 4;
  localparam int unsigned SC = 8;
  localparam int unsigned GC = 1;
  localparam int unsigned PW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [3:0]    wr_data;
  logic          wr_dp;
  logic          shift_en;
  logic          blank_lz;
  logic [PW-1:0] bright;
  logic [7:0]    sseg_n;
  logic [N-1:0]  ldsel;

  int n_cmp = 0;
  int n_err = 0;

  sseg_scan_display #(
    .N_DIGITS    (N),
    .SLOT_CYCLES (SC),
    .GUARD_CYCLES(GC),
    .PWM_W       (PW)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_clear   (clr),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_wr_dp   (wr_dp),
    .i_shift_en(shift_en),
    .i_blank_lz(blank_lz),
    .i_bright  (bright),
    .o_sseg_n  (sseg_n),
    .o_ldsel   (ldsel)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_digit(input logic [1:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic shift_digit(input logic [3:0] d, input logic p);
    shift_en = 1'b1; wr_data = d; wr_dp = p;
    tick();
    shift_en = 1'b0;
  endtask

  task automatic clear_all();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Waits (bounded) for the given select pattern, then checks select and segments.
  task automatic check_slot(input string tag, input logic [N-1:0] sel, input logic [7:0] seg);
    for (int i = 0; i < 64; i++) begin
      tick();
      if (ldsel == sel) break;
    end
    check_eq({tag, "_sel"}, 32'(ldsel), 32'(sel));
    check_eq({tag, "_seg"}, 32'(sseg_n), 32'(seg));
  endtask

  // Counts driven cycles over 4 full slots; also flags more than one select low.
  task automatic check_duty(input string tag, input int exp_on);
    int on_cnt;
    int multi;
    on_cnt = 0;
    multi  = 0;
    tick();
    tick();
    for (int i = 0; i < 4 * SC; i++) begin
      tick();
      if (ldsel != '1) on_cnt++;
      if ($countones(~ldsel) > 1) multi++;
    end
    check_eq({tag, "_on"}, 32'(on_cnt), 32'(exp_on));
    check_eq({tag, "_onehot"}, 32'(multi), 32'(0));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0;
    shift_en = 1'b0; blank_lz = 1'b0; bright = 2'b11;
    tick();
    check_eq("rst_seg", 32'(sseg_n), 32'hFF);
    check_eq("rst_sel", 32'(ldsel), 32'hF);
    rst = 1'b0;
    repeat (13) tick();

    // 1: reset mid-scan forces outputs off at once; first digit after guard + latency.
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_seg", 32'(sseg_n), 32'hFF);
    check_eq("midrst_sel", 32'(ldsel), 32'hF);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("guard_sel", 32'(ldsel), 32'hF);
    check_eq("guard_seg", 32'(sseg_n), 32'hFF);
    tick();
    check_eq("first_sel", 32'(ldsel), 32'hE);
    check_eq("first_seg", 32'(sseg_n), 32'hC0);

    // 2: addressed write with dp.
    write_digit(2'd2, 4'hA, 1'b1);
    check_slot("wr_s2", 4'b1011, 8'h08);
    check_slot("wr_s3", 4'b0111, 8'hC0);
    check_slot("wr_s0", 4'b1110, 8'hC0);
    check_slot("wr_s1", 4'b1101, 8'hC0);

    // 3: shift in 1..5; the 1 falls off the left end.
    clear_all();
    for (int v = 1; v <= 5; v++) shift_digit(4'(v), 1'b0);
    check_slot("sh_s3", 4'b0111, 8'hA4);
    check_slot("sh_s0", 4'b1110, 8'h92);
    check_slot("sh_s1", 4'b1101, 8'h99);
    check_slot("sh_s2", 4'b1011, 8'hB0);

    // 4: leading-zero blanking on {0,0,7,0}.
    clear_all();
    write_digit(2'd1, 4'h7, 1'b0);
    blank_lz = 1'b1;
    check_slot("lz_s3", 4'b0111, 8'hFF);
    check_slot("lz_s0", 4'b1110, 8'hC0);
    check_slot("lz_s1", 4'b1101, 8'hF8);
    check_slot("lz_s2", 4'b1011, 8'hFF);
    // A lit dp on the top digit stops blanking below it.
    write_digit(2'd3, 4'h0, 1'b1);
    check_slot("lzdp_s3", 4'b0111, 8'h40);
    check_slot("lzdp_s2", 4'b1011, 8'hC0);
    blank_lz = 1'b0;

    // 5: brightness duty cycle (7 drivable cycles per slot).
    bright = 2'b01;
    check_duty("pwm1", 4);
    bright = 2'b10;
    check_duty("pwm2", 12);
    bright = 2'b00;
    check_duty("pwm0", 0);
    bright = 2'b11;
    check_duty("pwm3", 28);

    // 6: clear wins over write and shift in the same cycle.
    for (int a = 0; a < 4; a++) write_digit(2'(a), 4'h9, 1'b1);
    check_slot("pre_s1", 4'b1101, 8'h10);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hF; wr_dp = 1'b1; shift_en = 1'b1;
    tick();
    clr = 1'b0; wr_en = 1'b0; shift_en = 1'b0;
    check_slot("clr_s0", 4'b1110, 8'hC0);
    check_slot("clr_s1", 4'b1101, 8'hC0);
    check_slot("clr_s2", 4'b1011, 8'hC0);
    check_slot("clr_s3", 4'b0111, 8'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
